// File: rtl/pipe_adder_n.sv
// Chunked pipelined adder/subtractor: one CW-bit chunk per stage, carry registered between stages.
// Latency STAGES cycles from input transfer to out_valid; one operation per cycle.
// Backpressure: a single global advance stalls every stage while a valid result is not taken.
module pipe_adder_n #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int CW = WIDTH / STAGES;

    // Stage registers; operands shift right by CW per stage so that the
    // chunk a stage consumes is always at the bottom of its input vector.
    logic             vld_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             cy_q  [STAGES];
    logic             ov_q;

    logic             vld_in [STAGES];
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             cy_in  [STAGES];
    logic [CW:0]      add_r  [STAGES];
    logic [WIDTH-1:0] a_nx   [STAGES];
    logic [WIDTH-1:0] b_nx   [STAGES];
    logic [WIDTH-1:0] s_nx   [STAGES];
    logic             ov_nx;
    logic             adv;

    assign adv       = !vld_q[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign c_out     = cy_q[STAGES-1];
    assign overflow  = ov_q;

    always_comb begin
        vld_in[0] = in_valid;
        a_in[0]   = a;
        b_in[0]   = sub ? ~b : b;
        cy_in[0]  = c_in ^ sub;
        s_in[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            vld_in[k] = vld_q[k-1];
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            cy_in[k]  = cy_q[k-1];
            s_in[k]   = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            add_r[k] = {1'b0, a_in[k][CW-1:0]} + {1'b0, b_in[k][CW-1:0]}
                     + {{CW{1'b0}}, cy_in[k]};
            a_nx[k]  = a_in[k] >> CW;
            b_nx[k]  = b_in[k] >> CW;
            // New chunk enters at the top; after STAGES shifts chunk 0 lands at bit 0.
            s_nx[k]  = (WIDTH'(add_r[k][CW-1:0]) << (WIDTH - CW)) | (s_in[k] >> CW);
        end
        // Carry into the MSB recovered from the MSB sum bit and its operand bits.
        ov_nx = add_r[STAGES-1][CW]
              ^ a_in[STAGES-1][CW-1] ^ b_in[STAGES-1][CW-1] ^ add_r[STAGES-1][CW-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                cy_q[k]  <= 1'b0;
            end
            ov_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_in[k];
                a_q[k]   <= a_nx[k];
                b_q[k]   <= b_nx[k];
                s_q[k]   <= s_nx[k];
                cy_q[k]  <= add_r[k][CW];
            end
            ov_q <= ov_nx;
        end
    end
endmodule
